alu_exec_seq: RTL and testbench

- Multi-cycle execute sequencer for the 8-bit ALU.
- Accepts one ALU operation request per handshake and fetches operands from the register file through a single asynchronous read port.
- Drives ALU mode/operands/enable, captures the result and flags, then writes back to the register file and the architectural flags register.
- Sits between instruction decode and the ALU/register file.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_exec_seq_if.sv | 27 ++
 rtl/alu_exec_seq.sv | 159 +++++++++++++++
 tb/tb_alu_exec_seq.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode codes, flag bit positions, mode decode.
// Also holds the execute-sequencer state type.
package alu_pkg;

   localparam logic [3:0] M_ADD  = 4'b0000;
   localparam logic [3:0] M_SUB  = 4'b0001;
   localparam logic [3:0] M_AND  = 4'b0010;
   localparam logic [3:0] M_NOT  = 4'b0011;
   localparam logic [3:0] M_OR   = 4'b0100;
   localparam logic [3:0] M_XOR  = 4'b0101;
   localparam logic [3:0] M_XNOR = 4'b0110;
   localparam logic [3:0] M_INC  = 4'b0111;
   localparam logic [3:0] M_SHL  = 4'b1000;
   localparam logic [3:0] M_SHR  = 4'b1001;
   localparam logic [3:0] M_ROL  = 4'b1010;
   localparam logic [3:0] M_ROR  = 4'b1011;
   localparam logic [3:0] M_PASS = 4'b1100;
   localparam logic [3:0] M_NAND = 4'b1101;
   localparam logic [3:0] M_NOR  = 4'b1110;
   localparam logic [3:0] M_NEG  = 4'b1111;

   localparam int FL_Z = 3;
   localparam int FL_C = 2;
   localparam int FL_S = 1;
   localparam int FL_O = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD1,
      ST_RD2,
      ST_EXEC,
      ST_WB
   } exec_st_e;

   function automatic logic uses_op1(input logic [3:0] m);
      case (m)
         M_NOT, M_SHL, M_SHR, M_NEG: return 1'b0;
         default:                    return 1'b1;
      endcase
   endfunction

   function automatic logic mode_sets_carry(input logic [3:0] m);
      case (m)
         M_AND, M_NOT, M_OR, M_XOR, M_XNOR,
         M_ROL, M_ROR, M_PASS, M_NAND, M_NOR: return 1'b0;
         default:                             return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/alu_exec_seq_if.sv
// Request handshake between decode (master) and the execute sequencer.
interface alu_exec_seq_if #(
   parameter int AW = 3,
   parameter int DW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_mode;
   logic [AW-1:0] req_src1;
   logic [AW-1:0] req_src2;
   logic [AW-1:0] req_dst;
   logic          req_use_imm;
   logic [DW-1:0] req_imm;
   logic          req_cmp;

   modport master (
      output req_valid, req_mode, req_src1, req_src2,
      output req_dst, req_use_imm, req_imm, req_cmp,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_mode, req_src1, req_src2,
      input  req_dst, req_use_imm, req_imm, req_cmp,
      output req_ready
   );
endinterface

// File: rtl/alu_exec_seq.sv
// Multi-cycle ALU execute sequencer: read operands, execute, write back.
// Optional macro ALU_EXEC_CMP_EN: compare requests skip register write-back.
module alu_exec_seq
   import alu_pkg::*;
#(
   parameter int AW = 3,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_exec_seq_if.slave req,
   output logic [AW-1:0] rf_rd_addr,
   input  logic [DW-1:0] rf_rd_data,
   output logic          alu_en,
   output logic [3:0]    alu_mode,
   output logic [DW-1:0] alu_op1,
   output logic [DW-1:0] alu_op2,
   input  logic [DW-1:0] alu_out,
   input  logic [3:0]    alu_flags,
   output logic          rf_wr_en,
   output logic [AW-1:0] rf_wr_addr,
   output logic [DW-1:0] rf_wr_data,
   output logic [3:0]    flags_q,
   output logic          busy,
   output logic          done
);

   exec_st_e      st_q, st_d;
   logic [3:0]    mode_q;
   logic [AW-1:0] src2_q, dst_q;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          use_imm_q;
   logic [DW-1:0] op1_q, op2_q, res_q;
   logic [3:0]    fl_q;
   logic          alu_en_q, wr_en_q, done_q;
   logic          busy_q, ready_q, wr_ok;

   // Outputs are registered, so decode them from the next state.
   always_comb begin
      st_d      = st_q;
      rd_addr_d = '0;
      unique case (st_q)
         ST_IDLE: begin
            if (req.req_valid) begin
               if (uses_op1(req.req_mode)) begin
                  st_d      = ST_RD1;
                  rd_addr_d = req.req_src1;
               end else if (!req.req_use_imm) begin
                  st_d      = ST_RD2;
                  rd_addr_d = req.req_src2;
               end else begin
                  st_d = ST_EXEC;
               end
            end
         end
         ST_RD1: begin
            if (use_imm_q) begin
               st_d = ST_EXEC;
            end else begin
               st_d      = ST_RD2;
               rd_addr_d = src2_q;
            end
         end
         ST_RD2:  st_d = ST_EXEC;
         ST_EXEC: st_d = ST_WB;
         ST_WB:   st_d = ST_IDLE;
         default: st_d = ST_IDLE;
      endcase
   end

`ifdef ALU_EXEC_CMP_EN
   logic cmp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_q <= 1'b0;
      end else if (st_q == ST_IDLE && req.req_valid) begin
         cmp_q <= req.req_cmp;
      end
   end

   assign wr_ok = !cmp_q;
`else
   logic unused_cmp;

   assign unused_cmp = req.req_cmp;
   assign wr_ok      = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= ST_IDLE;
         mode_q    <= '0;
         src2_q    <= '0;
         dst_q     <= '0;
         use_imm_q <= 1'b0;
         op1_q     <= '0;
         op2_q     <= '0;
         res_q     <= '0;
         fl_q      <= '0;
         flags_q   <= '0;
         rd_addr_q <= '0;
         alu_en_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         st_q      <= st_d;
         rd_addr_q <= rd_addr_d;
         alu_en_q  <= (st_d == ST_EXEC);
         wr_en_q   <= (st_d == ST_WB) && wr_ok;
         done_q    <= (st_d == ST_WB);
         busy_q    <= (st_d != ST_IDLE);
         ready_q   <= (st_d == ST_IDLE);
         unique case (st_q)
            ST_IDLE: begin
               if (req.req_valid) begin
                  mode_q    <= req.req_mode;
                  src2_q    <= req.req_src2;
                  dst_q     <= req.req_dst;
                  use_imm_q <= req.req_use_imm;
                  op1_q     <= '0;
                  if (req.req_use_imm) begin
                     op2_q <= req.req_imm;
                  end
               end
            end
            ST_RD1:  op1_q <= rf_rd_data;
            ST_RD2:  op2_q <= rf_rd_data;
            ST_EXEC: begin
               res_q <= alu_out;
               fl_q  <= alu_flags;
            end
            ST_WB: begin
               flags_q <= fl_q;
               // Logic ops leave the architectural carry untouched.
               if (!mode_sets_carry(mode_q)) begin
                  flags_q[FL_C] <= flags_q[FL_C];
               end
            end
            default: ;
         endcase
      end
   end

   assign req.req_ready = ready_q;
   assign rf_rd_addr    = rd_addr_q;
   assign alu_en        = alu_en_q;
   assign alu_mode      = alu_en_q ? mode_q : 4'd0;
   assign alu_op1       = op1_q;
   assign alu_op2       = op2_q;
   assign rf_wr_en      = wr_en_q;
   assign rf_wr_addr    = dst_q;
   assign rf_wr_data    = res_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Testbench for alu_exec_seq: ALU/register-file stubs, vector table,
// corner-case sequences and a randomized run against a reference model.
module tb_alu_exec_seq;

   localparam int AW = 3;
   localparam int DW = 8;
`ifdef ALU_EXEC_CMP_EN
   localparam bit CMP_EN = 1'b1;
`else
   localparam bit CMP_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] mode;
      logic [2:0] s1;
      logic [2:0] s2;
      logic [2:0] d;
      logic       ie;
      logic [7:0] imm;
      logic       cmp;
   } req_t;

   typedef struct {
      req_t       r;
      logic [7:0] res;
      logic [3:0] fl;
      int         lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_exec_seq_if #(.AW(AW), .DW(DW)) rq();

   logic [AW-1:0] rf_rd_addr, rf_wr_addr;
   logic [DW-1:0] rf_rd_data, alu_op1, alu_op2, alu_out, rf_wr_data;
   logic [3:0]    alu_mode, alu_flags, flags_q;
   logic          alu_en, rf_wr_en, busy, done;

   alu_exec_seq #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req(rq.slave),
      .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
      .alu_en(alu_en), .alu_mode(alu_mode),
      .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
      .rf_wr_data(rf_wr_data), .flags_q(flags_q),
      .busy(busy), .done(done)
   );

   // 8-bit ALU behaviour: returns {result, z, c, s, o}
   function automatic logic [11:0] alu_ref(input logic [3:0] m,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
      logic [7:0] r;
      logic [8:0] t;
      logic       c, o;
      r = '0; t = '0; c = 1'b0; o = 1'b0;
      case (m)
         4'h0: begin
            t = {1'b0, a} + {1'b0, b};
            r = t[7:0]; c = t[8];
            o = (a[7] == b[7]) && (r[7] != a[7]);
         end
         4'h1: begin
            r = a - b; c = (a < b);
            o = (a[7] != b[7]) && (r[7] != a[7]);
         end
         4'h2: r = a & b;
         4'h3: r = ~b;
         4'h4: r = a | b;
         4'h5: r = a ^ b;
         4'h6: r = ~(a ^ b);
         4'h7: begin r = a + 8'd1; c = (a == 8'hFF); o = (a == 8'h7F); end
         4'h8: begin r = {b[6:0], 1'b0}; c = b[7]; end
         4'h9: begin r = {1'b0, b[7:1]}; c = b[0]; end
         4'hA: r = {a[6:0], a[7]};
         4'hB: r = {a[0], a[7:1]};
         4'hC: r = a;
         4'hD: r = ~(a & b);
         4'hE: r = ~(a | b);
         default: begin r = 8'h00 - b; c = (b != 8'h00); o = (b == 8'h80); end
      endcase
      return {r, (r == 8'h00), c, r[7], o};
   endfunction

   always_comb {alu_out, alu_flags} = alu_ref(alu_mode, alu_op1, alu_op2);

   logic [7:0] rf [0:7];
   logic       ld_en = 1'b0;
   logic [2:0] ld_a = '0;
   logic [7:0] ld_d = '0;
   int         wr_cnt = 0;
   logic [2:0] last_a = '0;
   logic [7:0] last_d = '0;

   assign rf_rd_data = rf[rf_rd_addr];

   always @(posedge clk) begin
      if (ld_en) rf[ld_a] <= ld_d;
      else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
      if (rf_wr_en) begin
         wr_cnt <= wr_cnt + 1;
         last_a <= rf_wr_addr;
         last_d <= rf_wr_data;
      end
   end

   logic [7:0] mrf [0:7];
   logic [3:0] mfl = 4'h0;
   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic req_t mkreq(input logic [3:0] m, input logic [2:0] s1,
                                  input logic [2:0] s2, input logic [2:0] d,
                                  input logic ie, input logic [7:0] imm,
                                  input logic cmp);
      req_t r;
      r.mode = m; r.s1 = s1; r.s2 = s2; r.d = d;
      r.ie = ie; r.imm = imm; r.cmp = cmp;
      return r;
   endfunction

   task automatic load(input logic [2:0] a, input logic [7:0] d);
      ld_en = 1'b1; ld_a = a; ld_d = d;
      @(posedge clk);
      #1 ld_en = 1'b0;
      mrf[a] = d;
   endtask

   task automatic drive(input req_t r);
      rq.req_mode = r.mode; rq.req_src1 = r.s1; rq.req_src2 = r.s2;
      rq.req_dst = r.d; rq.req_use_imm = r.ie; rq.req_imm = r.imm;
      rq.req_cmp = r.cmp;
   endtask

   // Expected outcome from the operation's definition and architectural state
   task automatic model(input req_t r, output logic [7:0] res,
                        output logic [3:0] fl, output int lat, output bit wr);
      logic       u1;
      logic [7:0] a, b;
      u1 = !(r.mode inside {4'h3, 4'h8, 4'h9, 4'hF});
      a = u1 ? mrf[r.s1] : 8'h00;
      b = r.ie ? r.imm : mrf[r.s2];
      {res, fl} = alu_ref(r.mode, a, b);
      if (r.mode inside {[4'h2:4'h6], [4'hA:4'hE]}) fl[2] = mfl[2];
      lat = 2 + int'(u1) + int'(!r.ie);
      wr = !(CMP_EN && r.cmp);
   endtask

   task automatic exec_req(input req_t r, input logic [7:0] e_res,
                           input logic [3:0] e_fl, input int e_lat,
                           input bit e_wr, input string tag);
      int w0, lat;
      bit acc, rdnz, bad;
      w0 = wr_cnt; acc = 0; lat = 0; rdnz = 0; bad = 0;
      drive(r);
      rq.req_valid = 1'b1;
      for (int i = 0; i < 8 && !acc; i++) begin
         @(negedge clk);
         acc = rq.req_ready;
      end
      chk({tag, ".accept"}, 32'(acc), 1);
      if (!acc) begin
         rq.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 rq.req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (rf_rd_addr != '0) rdnz = 1;
         if (rq.req_ready || !busy) bad = 1;
         if (done) begin
            lat = k;
            break;
         end
      end
      chk({tag, ".latency"}, lat, e_lat);
      chk({tag, ".ready_busy"}, 32'(bad), 0);
      if (e_lat == 2) chk({tag, ".rd_addr_zero"}, 32'(rdnz), 0);
      @(posedge clk);
      #1;
      chk({tag, ".writes"}, wr_cnt - w0, 32'(e_wr));
      if (e_wr) begin
         chk({tag, ".wr_addr"}, 32'(last_a), 32'(r.d));
         chk({tag, ".wr_data"}, 32'(last_d), 32'(e_res));
         mrf[r.d] = e_res;
      end
      chk({tag, ".flags"}, 32'(flags_q), 32'(e_fl));
      chk({tag, ".done_pulse"}, 32'(done), 0);
      mfl = e_fl;
   endtask

   vec_t tv [6];

   initial begin
      logic [7:0] res;
      logic [3:0] fl;
      int         lat, w0, cyc;
      bit         wr, bad, hit;
      int         acc_t [$];
      req_t       r;

      rq.req_valid = 1'b0;
      drive(mkreq(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0));

      tv[0] = '{mkreq(4'h0, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 1'b0), 8'h80, 4'b0011, 4};
      tv[1] = '{mkreq(4'h0, 3'd6, 3'd0, 3'd7, 1'b1, 8'h01, 1'b0), 8'h00, 4'b1100, 3};
      tv[2] = '{mkreq(4'h2, 3'd4, 3'd0, 3'd5, 1'b1, 8'h0F, 1'b0), 8'h00, 4'b1100, 3};
      tv[3] = '{mkreq(4'hF, 3'd3, 3'd4, 3'd5, 1'b1, 8'h01, 1'b0), 8'hFF, 4'b0110, 2};
      tv[4] = '{mkreq(4'h1, 3'd3, 3'd2, 3'd6, 1'b0, 8'h00, 1'b0), 8'h7F, 4'b0001, 4};
      tv[5] = '{mkreq(4'h3, 3'd1, 3'd4, 3'd2, 1'b0, 8'h00, 1'b0), 8'h0F, 4'b0000, 3};

      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst.ready", 32'(rq.req_ready), 1);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk("rst.wr_en", 32'(rf_wr_en), 0);
      chk("rst.alu_en", 32'(alu_en), 0);
      chk("rst.alu_mode", 32'(alu_mode), 0);
      chk("rst.flags", 32'(flags_q), 0);
      chk("rst.rd_addr", 32'(rf_rd_addr), 0);
      chk("rst.ops", 32'({alu_op1, alu_op2}), 0);

      load(3'd0, 8'h00); load(3'd1, 8'h7F); load(3'd2, 8'h01);
      load(3'd3, 8'h00); load(3'd4, 8'hF0); load(3'd5, 8'h00);
      load(3'd6, 8'hFF); load(3'd7, 8'h00);

      // Table vectors run in order; each builds on the previous state
      for (int i = 0; i < 6; i++) begin
         exec_req(tv[i].r, tv[i].res, tv[i].fl, tv[i].lat, 1'b1,
                  $sformatf("vec%0d", i));
      end

      load(3'd1, 8'h22); load(3'd2, 8'h22);
      exec_req(mkreq(4'h1, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 1'b1),
               8'h00, 4'b1000, 4, !CMP_EN, "cmp");

      // Back-to-back: valid held high, accepts spaced by latency+1
      r = mkreq(4'h5, 3'd1, 3'd2, 3'd4, 1'b0, 8'h00, 1'b0);
      model(r, res, fl, lat, wr);
      w0 = wr_cnt; cyc = 0; bad = 0;
      drive(r);
      rq.req_valid = 1'b1;
      for (int i = 0; i < 30 && acc_t.size() < 3; i++) begin
         @(negedge clk);
         cyc++;
         if (busy && rq.req_ready) bad = 1;
         if (!busy && !rq.req_ready) bad = 1;
         if (rq.req_ready) acc_t.push_back(cyc);
      end
      @(posedge clk);
      #1 rq.req_valid = 1'b0;
      hit = 0;
      for (int k = 0; k < 8 && !hit; k++) begin
         @(negedge clk);
         hit = done;
      end
      @(posedge clk);
      #1;
      chk("b2b.accepts", acc_t.size(), 3);
      if (acc_t.size() == 3) begin
         chk("b2b.gap1", acc_t[1] - acc_t[0], lat + 1);
         chk("b2b.gap2", acc_t[2] - acc_t[1], lat + 1);
      end
      chk("b2b.ready_vs_busy", 32'(bad), 0);
      chk("b2b.writes", wr_cnt - w0, 3);
      chk("b2b.wr_data", 32'(last_d), 32'(res));
      chk("b2b.flags", 32'(flags_q), 32'(fl));
      mrf[4] = res; mfl = fl;

      // Reset during EXEC: no write-back, flags cleared
      load(3'd0, 8'h80); load(3'd7, 8'h80);
      exec_req(mkreq(4'h0, 3'd0, 3'd7, 3'd6, 1'b0, 8'h00, 1'b0),
               8'h00, 4'b1101, 4, 1'b1, "pre_rst");
      drive(mkreq(4'h0, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 1'b0));
      w0 = wr_cnt;
      rq.req_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 rq.req_valid = 1'b0;
      hit = 0;
      for (int k = 0; k < 6 && !hit; k++) begin
         @(negedge clk);
         hit = alu_en;
      end
      chk("rst_exec.reached", 32'(hit), 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_exec.wr_en", 32'(rf_wr_en), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_exec.writes", wr_cnt - w0, 0);
      chk("rst_exec.flags", 32'(flags_q), 0);
      chk("rst_exec.ready", 32'(rq.req_ready), 1);
      chk("rst_exec.busy", 32'(busy), 0);
      mfl = 4'h0;

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0)
            load(3'($urandom_range(0, 7)), 8'($urandom));
         r = mkreq(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 8'($urandom),
                   1'($urandom_range(0, 1)));
         model(r, res, fl, lat, wr);
         exec_req(r, res, fl, lat, wr, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
